// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write-port controller.
package regfile_pkg;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NREG = 32;

  // Which requester produced the registered write.
  typedef enum logic {SRC_A, SRC_B} wb_src_t;

  // One writeback request as presented by a requester.
  typedef struct packed {
    logic          valid;
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard for long-latency (mul/div) destinations.
// Raises iss_stall on RAW/WAW hazards against destinations still in flight.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int AW   = regfile_pkg::AW,
  parameter int NREG = regfile_pkg::NREG
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          iss_valid,
  input  logic          iss_long,
  input  logic [AW-1:0] iss_rs,
  input  logic [AW-1:0] iss_rt,
  input  logic [AW-1:0] iss_rd,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  wb_src_t       clr_src,
  output logic          iss_stall
);

  logic [NREG-1:0] pend_q, pend_d;
  logic            set_en;

  // Hazard compare uses only the registered vector; a clear landing this
  // cycle is not bypassed, so the stall lifts one cycle after the commit.
  always_comb begin
    iss_stall = 1'b0;
    if (!reset && iss_valid)
      iss_stall = pend_q[iss_rs] || pend_q[iss_rt] || (iss_long && pend_q[iss_rd]);
  end

  assign set_en = iss_valid && iss_long && !iss_stall && (iss_rd != '0);

  // Next pending vector: clear on B commit first, then set, so set wins.
  always_comb begin
    pend_d = pend_q;
    if (clr_en && clr_src == SRC_B) pend_d[clr_addr] = 1'b0;
    if (set_en)                     pend_d[iss_rd]   = 1'b1;
    pend_d[0] = 1'b0;
  end

  // Pending state register.
  always_ff @(posedge clk) begin
    if (reset) pend_q <= '0;
    else       pend_q <= pend_d;
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-port controller: fixed-priority arbiter (A over B)
// with a starvation guard for B, a one-cycle write register toward the
// file, and the long-latency pending scoreboard.
module regfile_wb_ctrl
  import regfile_pkg::*;
#(
  parameter int DW       = regfile_pkg::DW,
  parameter int AW       = regfile_pkg::AW,
  parameter int NREG     = regfile_pkg::NREG,
  parameter int WAIT_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_valid,
  input  logic [AW-1:0] a_rd,
  input  logic [DW-1:0] a_data,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [AW-1:0] b_rd,
  input  logic [DW-1:0] b_data,
  output logic          b_ready,
  input  logic          iss_valid,
  input  logic          iss_long,
  input  logic [AW-1:0] iss_rs,
  input  logic [AW-1:0] iss_rt,
  input  logic [AW-1:0] iss_rd,
  output logic          iss_stall,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata
);

  localparam int BW = $clog2(WAIT_MAX + 1);

  logic [BW-1:0] b_wait_q, b_wait_d;
  logic          force_b;
  logic          grant_a, grant_b;

  logic          rf_we_q,    rf_we_d;
  logic [AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [DW-1:0] rf_wdata_q, rf_wdata_d;
  wb_src_t       rf_src_q,   rf_src_d;

  assign force_b = (b_wait_q >= BW'(WAIT_MAX));

  // Arbiter: A wins unless B has waited long enough; nothing granted in reset.
  always_comb begin
    grant_b = !reset && b_valid && (!a_valid || force_b);
    grant_a = !reset && a_valid && !grant_b;
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  // Starvation counter: counts cycles B is refused, saturating at WAIT_MAX.
  always_comb begin
    b_wait_d = b_wait_q;
    if (grant_b || !b_valid)    b_wait_d = '0;
    else if (!force_b)          b_wait_d = b_wait_q + 1'b1;
  end

  // Write register next state: address/data/source load on any grant and
  // hold otherwise; r0 completes the handshake but never asserts the strobe.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    rf_src_d   = rf_src_q;
    if (grant_a) begin
      rf_we_d    = (a_rd != '0);
      rf_waddr_d = a_rd;
      rf_wdata_d = a_data;
      rf_src_d   = SRC_A;
    end else if (grant_b) begin
      rf_we_d    = (b_rd != '0);
      rf_waddr_d = b_rd;
      rf_wdata_d = b_data;
      rf_src_d   = SRC_B;
    end
  end

  // Arbiter and write-port state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      b_wait_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      rf_src_q   <= SRC_A;
    end else begin
      b_wait_q   <= b_wait_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      rf_src_q   <= rf_src_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

  regfile_scoreboard #(.AW(AW), .NREG(NREG)) u_sb (
    .clk       (clk),
    .reset     (reset),
    .iss_valid (iss_valid),
    .iss_long  (iss_long),
    .iss_rs    (iss_rs),
    .iss_rt    (iss_rt),
    .iss_rd    (iss_rd),
    .clr_en    (rf_we_q),
    .clr_addr  (rf_waddr_q),
    .clr_src   (rf_src_q),
    .iss_stall (iss_stall)
  );

endmodule
